// File: rtl/fpu_wb_scheduler.sv
// -----------------------------------------------------------------------------
// fpu_wb_scheduler
//
// Writeback-slot scheduler for the single FP register-file write port. A
// shifting reservation table books the exact future cycle in which each
// accepted FPU op (latency known at issue) or FP load (fixed latency) will
// write back. This guarantees that two results never collide on the port.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_fpu_req_valid/rd/lat  FPU issue request (latency 1..DEPTH)
//   o_fpu_req_ready         FPU request accepted this cycle if valid
//   i_flush_ex              kills the FPU op issuing this cycle
//   i_ld_req_valid/rd       FP load writeback-slot request
//   o_ld_req_ready          load accepted this cycle if valid
//   o_wb_valid/rd/src       FP register write this cycle (src 1 = load)
//   o_inflight_cnt          number of occupied reservation slots
//   o_rd_pending            bit r set while any slot targets register r
//   o_lat_err               one-cycle pulse after an illegal-latency request
// -----------------------------------------------------------------------------
module fpu_wb_scheduler #(
    parameter int DEPTH      = 8,
    parameter int LD_LAT     = 2,
    parameter int STARVE_MAX = 4,
    parameter int LW         = $clog2(DEPTH) + 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_fpu_req_valid,
    input  logic [4:0]                 i_fpu_req_rd,
    input  logic [LW-1:0]              i_fpu_req_lat,
    output logic                       o_fpu_req_ready,
    input  logic                       i_flush_ex,
    input  logic                       i_ld_req_valid,
    input  logic [4:0]                 i_ld_req_rd,
    output logic                       o_ld_req_ready,
    output logic                       o_wb_valid,
    output logic [4:0]                 o_wb_rd,
    output logic                       o_wb_src,
    output logic [$clog2(DEPTH+1)-1:0] o_inflight_cnt,
    output logic [31:0]                o_rd_pending,
    output logic                       o_lat_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       src;   // 0 = FPU, 1 = load
    } slot_t;

    // r_slot[k] holds the result that writes back k cycles from now.
    slot_t         r_slot     [DEPTH];
    slot_t         w_slot_nxt [DEPTH];
    logic [SW-1:0] r_starve_cnt;
    logic [SW-1:0] w_starve_nxt;
    logic [CW-1:0] r_inflight_cnt;
    logic [CW-1:0] w_inflight_nxt;
    logic          r_lat_err;

    logic w_legal;
    logic w_fpu_tgt_busy;
    logic w_fpu_free;
    logic w_ld_free;
    logic w_conflict;
    logic w_boost;
    logic w_fpu_ready;
    logic w_ld_ready;
    logic w_fpu_acc;
    logic w_ld_acc;

    // ------------------------------------------------------------------
    // Target-slot availability, judged on the pre-shift table: slot[lat]
    // moves to slot[lat-1] on the same edge that the new entry lands there.
    // ------------------------------------------------------------------
    assign w_legal = (i_fpu_req_lat != '0) && (i_fpu_req_lat <= LW'(DEPTH));

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_fpu_tgt_busy = 1'b0;
        // lat == DEPTH targets the slot that is empty after the shift,
        // so it never matches here and is always free.
        for (int k = 1; k < DEPTH; k++) begin
            if (i_fpu_req_lat == LW'(k) && r_slot[k].valid) begin
                w_fpu_tgt_busy = 1'b1;
            end
        end
    end

    assign w_fpu_free = w_legal && !w_fpu_tgt_busy;

    generate
        if (LD_LAT >= DEPTH) begin : g_ld_always_free
            assign w_ld_free = 1'b1;
        end else begin : g_ld_slot
            assign w_ld_free = !r_slot[LD_LAT].valid;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbitration: both requesters want the same future cycle. The load
    // wins ties unless the FPU has lost STARVE_MAX times in a row.
    // ------------------------------------------------------------------
    assign w_conflict = i_fpu_req_valid && i_ld_req_valid && w_legal &&
                        (i_fpu_req_lat == LW'(LD_LAT));
    assign w_boost    = (r_starve_cnt == SW'(STARVE_MAX));

    assign w_ld_ready  = w_ld_free  && !(w_conflict &&  w_boost && w_fpu_free);
    assign w_fpu_ready = w_fpu_free && !(w_conflict && !w_boost && w_ld_free);

    assign w_fpu_acc = i_fpu_req_valid && w_fpu_ready && !i_flush_ex;
    assign w_ld_acc  = i_ld_req_valid  && w_ld_ready;

    // ------------------------------------------------------------------
    // Next-state table: shift down by one, then insert accepted requests
    // at index (latency - 1) of the shifted table.
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < DEPTH - 1; k++) begin
            w_slot_nxt[k] = r_slot[k+1];
        end
        w_slot_nxt[DEPTH-1] = '0;

        if (w_ld_acc) begin
            w_slot_nxt[LD_LAT-1] = slot_t'{valid: 1'b1, rd: i_ld_req_rd, src: 1'b1};
        end

        for (int k = 0; k < DEPTH; k++) begin
            if (w_fpu_acc && i_fpu_req_lat == LW'(k + 1)) begin
                w_slot_nxt[k] = slot_t'{valid: 1'b1, rd: i_fpu_req_rd, src: 1'b0};
            end
        end

        w_inflight_nxt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_inflight_nxt = w_inflight_nxt + CW'(w_slot_nxt[k].valid);
        end
    end

    // Only a lost tie advances the counter; a stall on an occupied slot holds it.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!i_fpu_req_valid || i_flush_ex || w_fpu_acc) begin
            w_starve_nxt = '0;
        end else if (w_fpu_free && w_conflict && !w_fpu_ready && !w_boost) begin
            w_starve_nxt = r_starve_cnt + SW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the reservation table is reset entry by entry. In-flight
            // bookings must be discarded, and o_rd_pending/o_wb_* are driven
            // straight from it, so it cannot be left as uninitialised storage.
            for (int k = 0; k < DEPTH; k++) begin
                r_slot[k] <= '0;
            end
            r_starve_cnt   <= '0;
            r_inflight_cnt <= '0;
            r_lat_err      <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                r_slot[k] <= w_slot_nxt[k];
            end
            r_starve_cnt   <= w_starve_nxt;
            r_inflight_cnt <= w_inflight_nxt;
            r_lat_err      <= i_fpu_req_valid && !w_legal;
        end
    end

    always_comb begin
        o_rd_pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_slot[k].valid) begin
                o_rd_pending[r_slot[k].rd] = 1'b1;
            end
        end
    end

    assign o_fpu_req_ready = w_fpu_ready;
    assign o_ld_req_ready  = w_ld_ready;
    assign o_wb_valid      = r_slot[0].valid;
    assign o_wb_rd         = r_slot[0].rd;
    assign o_wb_src        = r_slot[0].src;
    assign o_inflight_cnt  = r_inflight_cnt;
    assign o_lat_err       = r_lat_err;

endmodule

// File: doc/fpu_wb_scheduler.md
# fpu_wb_scheduler

Writeback-slot scheduler for the single FP register-file write port. Arbitrates between the variable-latency FPU issue stream (latency known at issue) and the fixed-latency FP load return path. It reserves the exact future cycle in which each result will write back, so two results never collide on the port. Sits beside the FP scoreboard at the ID/EX boundary and drives FP WB write-enable and destination.

## Interface
- DEPTH, 8: reservation-table depth; maximum legal FPU latency.
- LD_LAT, 2: fixed load latency from acceptance to writeback (1..DEPTH).
- STARVE_MAX, 4: number of consecutive conflict losses before the FPU gets priority.
- LW: $clog2(DEPTH)+1, the latency field width.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- fpu_req_valid  in  1  FPU op wants to issue.
- fpu_req_rd  in  5  FPU destination register.
- fpu_req_lat  in  LW  FPU latency in cycles.
- fpu_req_ready  out  1  FPU issue accepted this cycle if valid.
- flush_ex  in  1  kill the FPU op issuing this cycle.
- ld_req_valid  in  1  FP load wants a writeback slot.
- ld_req_rd  in  5  load destination register.
- ld_req_ready  out  1  load accepted this cycle if valid.
- wb_valid  out  1  FP register write this cycle.
- wb_rd  out  5  write destination.
- wb_src  out  1  0 = FPU, 1 = load.
- inflight_cnt  out  $clog2(DEPTH+1)  number of occupied slots.
- rd_pending  out  32  bit r set if any slot holds rd = r.
- lat_err  out  1  one-cycle pulse for an illegal latency request.

## Operation
- **Reservation table:** slot[0..DEPTH-1], each holding {valid, rd, src}. Every cycle all entries shift down by one: slot[k] ← slot[k+1], and slot[DEPTH-1] ← empty.
- **Writeback outputs:** wb_valid/wb_rd/wb_src = slot[0], taken directly from registers.
- **Legal latency:** fpu_req_lat in 1..DEPTH; `legal = (lat ≥ 1) & (lat ≤ DEPTH)`.
- **FPU target free:** `fpu_free = legal & (lat == DEPTH | !slot[lat].valid)`. The comparison is on the pre-shift table.
- **Load target free:** `ld_free = !slot[LD_LAT].valid`, or always free when LD_LAT == DEPTH.
- **Conflict:** `conflict = fpu_req_valid & ld_req_valid & legal & lat == LD_LAT`.
- **Boost:** `boost = (starve_cnt == STARVE_MAX)`.
- **ld_req_ready** = `ld_free & !(conflict & boost & fpu_free)`.
- **fpu_req_ready** = `fpu_free & !(conflict & !boost & ld_free)`.
- **Write on accept:** an accepted request writes slot index (lat−1) of the post-shift table. A load writes index LD_LAT−1 with src = 1.
  - FPU accept = `fpu_req_valid & fpu_req_ready & !flush_ex`.
  - Load accept = `ld_req_valid & ld_req_ready`.
- **Flush:** flush_ex does not affect in-flight reservations; they always complete.
- **Starvation counter** (starve_cnt, saturating at STARVE_MAX):
  - Increment when fpu_req_valid & fpu_free & conflict & !fpu_req_ready.
  - Clear on FPU accept, on flush_ex, or when fpu_req_valid = 0.
  - Hold otherwise, e.g. stalled by an occupied slot.
- **lat_err:** registered; set for one cycle after any cycle with fpu_req_valid & !legal. An illegal request is never ready.
- **Derived outputs:**
  - inflight_cnt is registered, equal to the popcount of the next-state table.
  - rd_pending is combinational: the OR over valid slots of the decoded rd.
- **Reset** (synchronous, highest priority): all slots invalid, starve_cnt = 0. wb_valid = 0, wb_rd = 0, wb_src = 0, inflight_cnt = 0, lat_err = 0, rd_pending = 0. Reservations in flight at reset are discarded; no writeback occurs for them.

## Timing
- FPU accepted in cycle t with latency L → wb_valid = 1 in cycle t+L, for exactly one cycle.
- Load accepted in cycle t → writeback in cycle t+LD_LAT.
- Ready signals are combinational from the current table and both requests; there is no valid→ready loop on the same port.
- A slot whose contents leave as slot[0] in cycle t can be re-targeted in cycle t; the shift and the insert happen on the same edge.
- Equal priority is never undecided: the load wins unless boost is set.
- A stall caused by an occupied slot does not advance starve_cnt.
- Both requesters may be accepted in the same cycle when their targets differ.
- inflight_cnt updates one cycle after accept or writeback.

## Test plan
- **Single issue:** after reset, FPU rd = 5, lat = 4 at cycle 0 → ready = 1; wb_valid = 1, wb_rd = 5, wb_src = 0 at cycle 4 only; inflight_cnt = 1 during cycles 1–4, then 0 at cycle 5.
- **Slot collision:** FPU lat 6 (rd 1) at t, then FPU lat 5 (rd 2) at t+1 → ready = 0 at t+1; accepted at t+2; writebacks at t+6 (rd 1) and t+7 (rd 2).
- **Simultaneous load and FPU:** load rd 3 with FPU lat 2 rd 7 at t → ld_req_ready = 1, fpu_req_ready = 0; FPU accepted at t+1; wb rd 3 at t+2 (src 1), rd 7 at t+3 (src 0).
- **Starvation:** load valid every cycle while the FPU holds lat 2 from t → FPU loses t..t+3; at t+4 fpu_req_ready = 1, ld_req_ready = 0, starve_cnt clears; the load resumes at t+5.
- **Flush and illegal latency:**
  - flush_ex with a valid FPU lat 3 → no reservation, no writeback, starve_cnt = 0.
  - lat = 0 or DEPTH+1 → ready = 0, lat_err pulses the next cycle.
- **Reset mid-operation:** three reservations pending, rst for one cycle → no writeback afterwards, rd_pending = 0, inflight_cnt = 0; new issues behave as after a cold reset.
